// File: rtl/button_event_decoder.sv
// button_event_decoder
//
// Turns the debounced button level into one-cycle event pulses (press,
// release, click, double click, long press) plus a "held" level, so that
// downstream counters/LEDs/display logic need no edge or timing detection.
//
// Ports
//   i_Clk           system clock, rising edge
//   i_Rst_L         asynchronous active-low reset
//   i_Debounced     debounced button level, 1 = pressed
//   o_Press         pulse, first sample of a high level
//   o_Release       pulse, first sample of a low level
//   o_Click         pulse, single short press confirmed by gap timeout
//   o_Double_Click  pulse, release of the second short press
//   o_Long_Press    pulse, press reaches LONG_PRESS_LIMIT samples
//   o_Held          level, button considered held
//
// State table
//   IDLE           | waiting for a press
//   PRESSED        | first press in progress, not yet long
//   LONG_HELD      | long press already reported, waiting for release
//   WAIT_SECOND    | short press released, timing the gap for a second press
//   SECOND_PRESSED | second press of a possible double click in progress

module button_event_decoder #(
    parameter int LONG_PRESS_LIMIT = 25000000,
    parameter int DOUBLE_CLICK_GAP = 6250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Debounced,
    output logic o_Press,
    output logic o_Release,
    output logic o_Click,
    output logic o_Double_Click,
    output logic o_Long_Press,
    output logic o_Held
);

    localparam int MAX_LIMIT = (LONG_PRESS_LIMIT > DOUBLE_CLICK_GAP) ?
                               LONG_PRESS_LIMIT : DOUBLE_CLICK_GAP;
    localparam int CNT_W     = (MAX_LIMIT > 1) ? $clog2(MAX_LIMIT) : 1;

    // The counter is cleared on the sample that enters a state, so on the
    // N-th sample of a run (entry sample = 1st) it reads N-2.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_LIMIT - 2);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_CLICK_GAP - 2);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } state_t;

    state_t           r_State;
    state_t           w_Next;
    logic             r_Prev;
    logic [CNT_W-1:0] r_Count;

    logic w_Rise;
    logic w_Fall;
    logic w_Long_Hit;
    logic w_Gap_Hit;
    logic w_Click;
    logic w_Double;
    logic w_Long;
    logic w_Held;

    assign w_Rise     = i_Debounced & ~r_Prev;
    assign w_Fall     = ~i_Debounced & r_Prev;
    assign w_Long_Hit = (r_Count == LONG_LAST);
    assign w_Gap_Hit  = (r_Count == GAP_LAST);

    always_comb begin
        w_Next   = r_State;
        w_Click  = 1'b0;
        w_Double = 1'b0;
        w_Long   = 1'b0;
        case (r_State)
            IDLE: begin
                if (w_Rise) w_Next = PRESSED;
            end
            PRESSED: begin
                // A release landing exactly on the limit sample still counts
                // as a long press; the button is already up, so go idle.
                if (w_Long_Hit) begin
                    w_Long = 1'b1;
                    w_Next = w_Fall ? IDLE : LONG_HELD;
                end else if (w_Fall) begin
                    w_Next = WAIT_SECOND;
                end
            end
            LONG_HELD: begin
                if (w_Fall) w_Next = IDLE;
            end
            WAIT_SECOND: begin
                // Edge beats the gap timeout on the same sample.
                if (w_Rise) begin
                    w_Next = SECOND_PRESSED;
                end else if (w_Gap_Hit) begin
                    w_Click = 1'b1;
                    w_Next  = IDLE;
                end
            end
            SECOND_PRESSED: begin
                // Turning long: the first press is reported as a click.
                if (w_Long_Hit) begin
                    w_Click = 1'b1;
                    w_Long  = 1'b1;
                    w_Next  = w_Fall ? IDLE : LONG_HELD;
                end else if (w_Fall) begin
                    w_Double = 1'b1;
                    w_Next   = IDLE;
                end
            end
            default: w_Next = IDLE;
        endcase
        w_Held = (w_Next == PRESSED) || (w_Next == LONG_HELD) ||
                 (w_Next == SECOND_PRESSED);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State        <= IDLE;
            r_Prev         <= 1'b0;
            r_Count        <= '0;
            o_Press        <= 1'b0;
            o_Release      <= 1'b0;
            o_Click        <= 1'b0;
            o_Double_Click <= 1'b0;
            o_Long_Press   <= 1'b0;
            o_Held         <= 1'b0;
        end else begin
            r_State        <= w_Next;
            r_Prev         <= i_Debounced;
            if (w_Next != r_State) begin
                r_Count <= '0;
            end else if (r_Count != '1) begin
                r_Count <= r_Count + 1'b1;
            end
            o_Press        <= w_Rise;
            o_Release      <= w_Fall;
            o_Click        <= w_Click;
            o_Double_Click <= w_Double;
            o_Long_Press   <= w_Long;
            o_Held         <= w_Held;
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Testbench for button_event_decoder with LONG_PRESS_LIMIT=8, DOUBLE_CLICK_GAP=6.
// The reference model tracks run lengths of high/low samples and whether a
// short press is pending, and derives every expected output from those.

module tb_button_event_decoder;

    localparam int L = 8;
    localparam int G = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic o_press, o_rel, o_click, o_dbl, o_long, o_held;

    button_event_decoder #(.LONG_PRESS_LIMIT(L), .DOUBLE_CLICK_GAP(G)) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Debounced    (din),
        .o_Press        (o_press),
        .o_Release      (o_rel),
        .o_Click        (o_click),
        .o_Double_Click (o_dbl),
        .o_Long_Press   (o_long),
        .o_Held         (o_held)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    bit   m_prev = 0;
    int   hi_run = 0;
    int   lo_run = 0;
    bit   pending = 0;
    bit   second = 0;
    bit   long_done = 0;
    logic [5:0] exp_vec = '0;
    int   sample_idx = 0;
    int   last_rise_idx = 0;
    int   last_fall_idx = 0;

    // observed pulse statistics
    int c_press, c_rel, c_click, c_dbl, c_long, c_held;
    int click_idx, long_idx;

    initial begin
        forever begin
            @(posedge clk);
            sample_idx++;
            if (!rst_n) begin
                m_prev = 0; hi_run = 0; lo_run = 0;
                pending = 0; second = 0; long_done = 0;
                exp_vec = '0;
            end else begin
                bit s, rise, fall, e_click, e_dbl, e_long;
                s = din;
                rise = s && !m_prev;
                fall = !s && m_prev;
                e_click = 0; e_dbl = 0; e_long = 0;
                if (s) begin
                    hi_run = rise ? 1 : hi_run + 1;
                    lo_run = 0;
                    if (rise) begin
                        long_done = 0;
                        second = pending;
                        pending = 0;
                        last_rise_idx = sample_idx;
                    end
                    if (!long_done && hi_run == L) begin
                        e_long = 1;
                        long_done = 1;
                        if (second) e_click = 1;
                        second = 0;
                    end
                end else begin
                    if (fall) begin
                        last_fall_idx = sample_idx;
                        lo_run = 1;
                        if (!long_done) begin
                            if (hi_run == L - 1) begin
                                e_long = 1;
                                if (second) e_click = 1;
                            end else if (second) begin
                                e_dbl = 1;
                            end else begin
                                pending = 1;
                            end
                        end
                        second = 0; long_done = 0; hi_run = 0;
                    end else begin
                        lo_run++;
                    end
                    if (pending && lo_run == G) begin
                        e_click = 1;
                        pending = 0;
                    end
                end
                m_prev = s;
                exp_vec = {rise, fall, e_click, e_dbl, e_long, s};
            end
        end
    end

    // per-cycle compare and pulse statistics
    initial begin
        forever begin
            logic [5:0] act;
            @(negedge clk);
            act = {o_press, o_rel, o_click, o_dbl, o_long, o_held};
            n_checks++;
            if (act === exp_vec) n_pass++;
            else $display("FAIL cycle %0d outputs{press,rel,click,dbl,long,held} actual=%b required=%b",
                          sample_idx, act, exp_vec);
            c_press += int'(o_press);
            c_rel   += int'(o_rel);
            c_click += int'(o_click);
            c_dbl   += int'(o_dbl);
            c_long  += int'(o_long);
            c_held  += int'(o_held);
            if (o_click) click_idx = sample_idx;
            if (o_long)  long_idx  = sample_idx;
        end
    end

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, req);
    endtask

    task automatic clear_counts();
        c_press = 0; c_rel = 0; c_click = 0; c_dbl = 0; c_long = 0; c_held = 0;
        click_idx = -1; long_idx = -1;
    endtask

    task automatic drive(input bit lvl, input int n);
        repeat (n) begin
            @(negedge clk);
            #1 din = lvl;
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (n) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        clear_counts();
        // reset held with toggling input
        for (int i = 0; i < 6; i++) drive(bit'(i % 2 == 0), 1);
        check_int("reset_pulses", c_press + c_rel + c_click + c_dbl + c_long + c_held, 0);
        @(negedge clk);
        #1 begin din = 1'b0; rst_n = 1'b1; end
        drive(0, 4);
        check_int("post_reset_pulses", c_press + c_rel + c_click + c_dbl + c_long + c_held, 0);

        // short click
        clear_counts();
        drive(1, 3); drive(0, 10);
        check_int("click_press", c_press, 1);
        check_int("click_release", c_rel, 1);
        check_int("click_count", c_click, 1);
        check_int("click_held_cycles", c_held, 3);
        check_int("click_latency", click_idx - last_fall_idx, G - 1);

        // double click
        clear_counts();
        drive(1, 3); drive(0, 4); drive(1, 2); drive(0, 10);
        check_int("dbl_count", c_dbl, 1);
        check_int("dbl_no_click", c_click, 0);
        check_int("dbl_press", c_press, 2);

        // long press
        clear_counts();
        drive(1, 20); drive(0, 10);
        check_int("long_count", c_long, 1);
        check_int("long_latency", long_idx - last_rise_idx, L - 1);
        check_int("long_release", c_rel, 1);
        check_int("long_no_click", c_click, 0);
        check_int("long_held_cycles", c_held, 20);

        // gap boundary: rising edge on the G-th gap sample
        clear_counts();
        drive(1, 2); drive(0, G - 1); drive(1, 2); drive(0, 10);
        check_int("gap_edge_dbl", c_dbl, 1);
        check_int("gap_edge_no_click", c_click, 0);
        clear_counts();
        drive(1, 2); drive(0, 12);
        check_int("gap_full_click", c_click, 1);
        check_int("gap_full_dbl", c_dbl, 0);

        // reset while waiting for a second press
        clear_counts();
        drive(1, 2); drive(0, 3);
        din = 1'b0;
        pulse_reset(2);
        drive(0, 10);
        check_int("midreset_no_click", c_click, 0);
        clear_counts();
        drive(1, 2); drive(0, 10);
        check_int("after_reset_press", c_press, 1);
        check_int("after_reset_click", c_click, 1);

        // randomized runs, occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset(int'($urandom_range(1, 3)));
            drive(bit'(i % 2 == 0), int'($urandom_range(1, 12)));
        end
        drive(0, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
